// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter path: FSM encoding, control-flow
// opcodes used by pc_cntrl/decode, and default reset/trap vectors.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } pc_state_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_gen_if.sv
// Bundle between the pc_gen stage and its neighbours (pc_cntrl, regfile, imem,
// writeback). The slave modport is the pc_gen side.
interface pc_gen_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import pc_pkg::*;

  // No valid/ready pair here: stall is the only back-pressure. While stall=1 in
  // RUN, the stage holds pc, state and retire_cnt and ignores halt/pc_gen_out.
  logic             stall;
  logic             halt;
  logic             pc_gen_out;
  logic             jalr;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  rs1_data;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus4;
  logic             inst_valid;
  logic             misalign_trap;
  logic [XLEN-1:0]  trap_pc;
  logic             halted;
  logic [CNT_W-1:0] retire_cnt;
  pc_state_e        dbg_state;

  modport master (
    output stall, halt, pc_gen_out, jalr, imm, rs1_data,
    input  pc, pc_plus4, inst_valid, misalign_trap, trap_pc, halted,
           retire_cnt, dbg_state
  );

  modport slave (
    input  stall, halt, pc_gen_out, jalr, imm, rs1_data,
    output pc, pc_plus4, inst_valid, misalign_trap, trap_pc, halted,
           retire_cnt, dbg_state
  );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational control-flow target: pc+imm for branch/JAL, (rs1+imm)&~1 for
// JALR, plus a flag for targets that are not 4-byte aligned.
module pc_target_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic            i_jalr,
  output logic [XLEN-1:0] o_target,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;

  assign w_base       = i_jalr ? i_rs1_data : i_pc;
  assign w_sum        = w_base + i_imm;
  assign o_target     = i_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
  // Bit 0 is either cleared (JALR) or ignored; only bit 1 breaks alignment.
  assign o_misaligned = o_target[1];

endmodule

// File: rtl/pc_gen.sv
// Program-counter stage: holds the architectural PC, sequences boot/trap/halt,
// and counts retired instructions.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [XLEN-1:0] TRAP_VEC  = DEF_TRAP_VEC,
  parameter int              CNT_W     = 32
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);

  pc_state_e        r_state;
  pc_state_e        w_state_nxt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_trap_pc;
  logic             r_trap;
  logic [CNT_W-1:0] r_retire_cnt;

  logic [XLEN-1:0]  w_target;
  logic             w_misaligned;
  logic [XLEN-1:0]  w_pc_plus4;
  logic             w_run_go;
  logic             w_take_trap;
  logic             w_redirect;
  logic             w_seq;
  logic             w_retire;

  pc_target_calc #(.XLEN(XLEN)) u_target (
    .i_pc         (r_pc),
    .i_imm        (bus.imm),
    .i_rs1_data   (bus.rs1_data),
    .i_jalr       (bus.jalr),
    .o_target     (w_target),
    .o_misaligned (w_misaligned)
  );

  assign w_pc_plus4  = r_pc + XLEN'(4);
  assign w_run_go    = (r_state == RUN) && !bus.stall;
  assign w_take_trap = w_run_go && !bus.halt && bus.pc_gen_out && w_misaligned;
  assign w_redirect  = w_run_go && !bus.halt && bus.pc_gen_out && !w_misaligned;
  assign w_seq       = w_run_go && !bus.halt && !bus.pc_gen_out;
  // A halting instruction retires; a trapping one does not.
  assign w_retire    = w_run_go && !w_take_trap;

  always_ff @(posedge clk) begin
    if (rst) r_state <= BOOT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (w_run_go && bus.halt) w_state_nxt = HALT;
        else if (w_take_trap)     w_state_nxt = TRAP;
      end
      TRAP:    w_state_nxt = RUN;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_comb begin
    bus.inst_valid = (r_state == RUN);
    bus.halted     = (r_state == HALT);
    bus.dbg_state  = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_VEC;
      r_trap_pc    <= '0;
      r_trap       <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      r_trap <= w_take_trap;
      if (w_take_trap) begin
        r_trap_pc <= r_pc;
        r_pc      <= TRAP_VEC;
      end else if (w_redirect) begin
        r_pc <= w_target;
      end else if (w_seq) begin
        r_pc <= w_pc_plus4;
      end
      if (w_retire) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign bus.pc            = r_pc;
  assign bus.pc_plus4      = w_pc_plus4;
  assign bus.misalign_trap = r_trap;
  assign bus.trap_pc       = r_trap_pc;
  assign bus.retire_cnt    = r_retire_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset/boot, branch, JALR, misaligned trap, stall
// priority, halt and wrap, with hand-computed expected values.
module tb_pc_gen;
  import pc_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_gen_if #(.XLEN(32), .CNT_W(32)) bus ();

  pc_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic hl, input logic go,
                       input logic jr, input logic [31:0] im,
                       input logic [31:0] rs);
    bus.stall      = st;
    bus.halt       = hl;
    bus.pc_gen_out = go;
    bus.jalr       = jr;
    bus.imm        = im;
    bus.rs1_data   = rs;
  endtask

  task automatic boot_to_run();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", bus.pc, 32'h0); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.inst_valid); end
    checks++; if (bus.halted !== 1'b0 || bus.misalign_trap !== 1'b0) begin errors++; $display("FAIL reset_flags: halted %b trap %b exp 0 0", bus.halted, bus.misalign_trap); end
    checks++; if (bus.retire_cnt !== 32'd0 || bus.trap_pc !== 32'h0) begin errors++; $display("FAIL reset_cnt_trappc: cnt %0d trap_pc %h exp 0 0", bus.retire_cnt, bus.trap_pc); end
    checks++; if (bus.dbg_state !== BOOT) begin errors++; $display("FAIL reset_state: got %0d exp %0d", bus.dbg_state, BOOT); end
    rst = 1'b0;
    checks++; if (bus.inst_valid !== 1'b0 || bus.pc !== 32'h0) begin errors++; $display("FAIL boot_cycle: valid %b pc %h exp 0 0", bus.inst_valid, bus.pc); end
    step();
    checks++; if (bus.inst_valid !== 1'b1 || bus.pc !== 32'h0 || bus.retire_cnt !== 32'd0) begin errors++; $display("FAIL first_fetch: valid %b pc %h cnt %0d exp 1 0 0", bus.inst_valid, bus.pc, bus.retire_cnt); end
    step();
    checks++; if (bus.pc !== 32'h4 || bus.retire_cnt !== 32'd1) begin errors++; $display("FAIL seq_1: pc %h cnt %0d exp 4 1", bus.pc, bus.retire_cnt); end
    step();
    checks++; if (bus.pc !== 32'h8 || bus.retire_cnt !== 32'd2) begin errors++; $display("FAIL seq_2: pc %h cnt %0d exp 8 2", bus.pc, bus.retire_cnt); end
  endtask

  // Continues from pc=0x8, retire_cnt=2.
  task automatic test_stall_halt();
    drive(1, 1, 1, 0, 32'h40, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.pc !== 32'h8 || bus.retire_cnt !== 32'd2 || bus.halted !== 1'b0) begin errors++; $display("FAIL stall_hold_%0d: pc %h cnt %0d halted %b exp 8 2 0", i, bus.pc, bus.retire_cnt, bus.halted); end
    end
    drive(0, 1, 1, 0, 32'h40, 32'h0);
    step();
    checks++; if (bus.halted !== 1'b1 || bus.pc !== 32'h8 || bus.retire_cnt !== 32'd3 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL halt_enter: halted %b pc %h cnt %0d valid %b exp 1 8 3 0", bus.halted, bus.pc, bus.retire_cnt, bus.inst_valid); end
    for (int i = 0; i < 4; i++) begin
      drive(i[0], i[1], ~i[0], i[1], 32'h10, 32'h20);
      step();
      checks++; if (bus.halted !== 1'b1 || bus.pc !== 32'h8 || bus.retire_cnt !== 32'd3) begin errors++; $display("FAIL halt_frozen_%0d: halted %b pc %h cnt %0d exp 1 8 3", i, bus.halted, bus.pc, bus.retire_cnt); end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.pc !== 32'h0 || bus.halted !== 1'b0 || bus.retire_cnt !== 32'd0) begin errors++; $display("FAIL halt_reset: pc %h halted %b cnt %0d exp 0 0 0", bus.pc, bus.halted, bus.retire_cnt); end
  endtask

  task automatic test_branch_jal();
    boot_to_run();
    for (int i = 0; i < 4; i++) step();
    checks++; if (bus.pc !== 32'h10 || bus.pc_plus4 !== 32'h14) begin errors++; $display("FAIL br_setup: pc %h pc4 %h exp 10 14", bus.pc, bus.pc_plus4); end
    drive(0, 0, 1, 0, 32'hFFFF_FFF8, 32'h0);
    step();
    checks++; if (bus.pc !== 32'h8 || bus.retire_cnt !== 32'd5) begin errors++; $display("FAIL br_back: pc %h cnt %0d exp 8 5", bus.pc, bus.retire_cnt); end
    drive(0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0);
    step();
    checks++; if (bus.pc !== 32'hC || bus.retire_cnt !== 32'd6) begin errors++; $display("FAIL br_seq: pc %h cnt %0d exp c 6", bus.pc, bus.retire_cnt); end
  endtask

  // Continues from pc=0xC, retire_cnt=6.
  task automatic test_jalr();
    drive(0, 0, 1, 0, 32'h14, 32'h0);
    step();
    checks++; if (bus.pc !== 32'h20 || bus.pc_plus4 !== 32'h24) begin errors++; $display("FAIL jalr_setup: pc %h pc4 %h exp 20 24", bus.pc, bus.pc_plus4); end
    drive(0, 0, 1, 1, 32'h3, 32'h101);
    step();
    checks++; if (bus.pc !== 32'h104 || bus.retire_cnt !== 32'd8) begin errors++; $display("FAIL jalr_lsb: pc %h cnt %0d exp 104 8", bus.pc, bus.retire_cnt); end
    drive(0, 0, 1, 1, 32'h21, 32'hFFFF_FFF0);
    step();
    checks++; if (bus.pc !== 32'h10 || bus.retire_cnt !== 32'd9) begin errors++; $display("FAIL jalr_wrap: pc %h cnt %0d exp 10 9", bus.pc, bus.retire_cnt); end
  endtask

  // Continues from pc=0x10, retire_cnt=9.
  task automatic test_misalign();
    drive(0, 0, 1, 1, 32'h0, 32'h40);
    step();
    checks++; if (bus.pc !== 32'h40 || bus.retire_cnt !== 32'd10) begin errors++; $display("FAIL mis_setup: pc %h cnt %0d exp 40 10", bus.pc, bus.retire_cnt); end
    drive(0, 0, 1, 0, 32'h6, 32'h0);
    step();
    checks++; if (bus.pc !== 32'h100 || bus.misalign_trap !== 1'b1 || bus.trap_pc !== 32'h40) begin errors++; $display("FAIL mis_trap: pc %h trap %b trap_pc %h exp 100 1 40", bus.pc, bus.misalign_trap, bus.trap_pc); end
    checks++; if (bus.inst_valid !== 1'b0 || bus.retire_cnt !== 32'd10) begin errors++; $display("FAIL mis_bubble: valid %b cnt %0d exp 0 10", bus.inst_valid, bus.retire_cnt); end
    drive(1, 1, 1, 0, 32'h6, 32'h0);
    step();
    checks++; if (bus.misalign_trap !== 1'b0 || bus.inst_valid !== 1'b1 || bus.pc !== 32'h100 || bus.retire_cnt !== 32'd10) begin errors++; $display("FAIL mis_resume: trap %b valid %b pc %h cnt %0d exp 0 1 100 10", bus.misalign_trap, bus.inst_valid, bus.pc, bus.retire_cnt); end
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    checks++; if (bus.pc !== 32'h104 || bus.retire_cnt !== 32'd11 || bus.trap_pc !== 32'h40) begin errors++; $display("FAIL mis_after: pc %h cnt %0d trap_pc %h exp 104 11 40", bus.pc, bus.retire_cnt, bus.trap_pc); end
  endtask

  // Continues from pc=0x104, retire_cnt=11.
  task automatic test_wrap();
    drive(0, 0, 1, 1, 32'h0, 32'hFFFF_FFFC);
    step();
    checks++; if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_setup: pc %h pc4 %h exp fffffffc 0", bus.pc, bus.pc_plus4); end
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    checks++; if (bus.pc !== 32'h0 || bus.retire_cnt !== 32'd13) begin errors++; $display("FAIL wrap_seq: pc %h cnt %0d exp 0 13", bus.pc, bus.retire_cnt); end
  endtask

  task automatic test_reset_in_trap();
    boot_to_run();
    drive(0, 0, 1, 0, 32'h2, 32'h0);
    step();
    checks++; if (bus.misalign_trap !== 1'b1 || bus.trap_pc !== 32'h0 || bus.pc !== 32'h100) begin errors++; $display("FAIL rt_trap: trap %b trap_pc %h pc %h exp 1 0 100", bus.misalign_trap, bus.trap_pc, bus.pc); end
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    step();
    checks++; if (bus.pc !== 32'h104) begin errors++; $display("FAIL rt_run: pc %h exp 104", bus.pc); end
    drive(0, 0, 1, 0, 32'h2, 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.misalign_trap !== 1'b0 || bus.trap_pc !== 32'h0 || bus.pc !== 32'h0 || bus.dbg_state !== BOOT) begin errors++; $display("FAIL rt_reset: trap %b trap_pc %h pc %h state %0d exp 0 0 0 %0d", bus.misalign_trap, bus.trap_pc, bus.pc, bus.dbg_state, BOOT); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    test_reset();
    test_stall_halt();
    test_branch_jal();
    test_jalr();
    test_misalign();
    test_wrap();
    test_reset_in_trap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
